muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 The block SHALL have these ports: rst_n, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have these ports: start, input, 1, request a new operation; sampled only in IDLE.
REQ-004 The block SHALL have these ports: op, input, 1, operation select: 0 = unsigned multiply, 1 = unsigned divide.
REQ-005 The block SHALL have these ports: A and B, inputs, 32 each, operands (multiplicand/multiplier, or dividend/divisor); captured at accept.
REQ-006 The block SHALL have these ports: busy, output, 1, operation in progress.
REQ-007 The block SHALL have these ports: done, output, 1, one-cycle result-valid pulse.
REQ-008 The block SHALL have these ports: Hi and Lo, outputs, 32 each, product high/low, or remainder/quotient.
REQ-009 The block SHALL have these ports: div_by_zero, output, 1, last divide had B == 0.
REQ-010 The block SHALL have these ports: AS_X, AS_Y and AS_Sub, outputs (32, 32, 1), operands and mode driven to the external shared 32-bit add/sub unit.
REQ-011 The block SHALL have these ports: AS_S, input, 32, combinational sum/difference returned by that unit (no carry-out available).

Function
REQ-012 FSM states SHALL be IDLE, RUN and FIN; a 5-bit iteration counter counts 31 down to 0.
REQ-013 In IDLE, start=1 at edge E0 SHALL be accepted as follows:
- op, A and B latched; busy=1.
- Multiply: Hi=0, Lo=A, state goes to RUN.
- Divide: Hi=0, Lo=A, state goes to RUN.
REQ-014 Each RUN edge SHALL perform exactly one iteration; after 32 RUN edges (E1..E32) the state SHALL be FIN.
REQ-015 In FIN, done=1 and busy=1 with Hi/Lo final; the next edge SHALL return the state to IDLE.
REQ-016 Multiply iteration:
- Drive AS_X=Hi, AS_Y=B, AS_Sub=0.
- Carry derived as c = (Hi[31]&B[31]) | ((Hi[31]|B[31]) & ~AS_S[31]).
- If Lo[0]=1: {Hi,Lo} <= {c, AS_S, Lo[31:1]} truncated to 64 bits; else {Hi,Lo} <= {1'b0, Hi, Lo[31:1]}.
REQ-017 Divide iteration:
- r' = {Hi[30:0], Lo[31]}; top = Hi[31].
- Drive AS_X=r', AS_Y=B, AS_Sub=1.
- Borrow derived as bw = (~r'[31]&B[31]) | (~(r'[31]^B[31]) & AS_S[31]).
- If top | ~bw: Hi <= AS_S and Lo <= {Lo[30:0],1}; else Hi <= r' and Lo <= {Lo[30:0],0}.
REQ-018 Final results SHALL be as follows:
- Multiply: {Hi,Lo} = A*B (64-bit).
- Divide: Lo = A/B and Hi = A%B (unsigned).
REQ-019 Divide with B==0 SHALL skip RUN: E0 leads directly to FIN with Hi=A, Lo=32'hFFFFFFFF, div_by_zero=1.
REQ-020 div_by_zero SHALL update at every accept (0 unless divide-by-zero) and hold until the next accept.
REQ-021 The following inputs SHALL be ignored:
- start while busy.
- start in the FIN cycle.
- op/A/B changes after accept.
REQ-022 Hi/Lo SHALL hold the last result in IDLE until the next accept.
REQ-023 Outside RUN, AS_X=0, AS_Y=0 and AS_Sub=0; AS_* SHALL depend only on registered state (no start/A/B combinational path).
REQ-024 done SHALL be high for exactly one cycle per accepted operation.

Reset
REQ-025 rst_n=0 SHALL asynchronously force:
- state IDLE.
- counter 0.
- busy=0, done=0, div_by_zero=0.
- Hi=0, Lo=0.
- AS_X=0, AS_Y=0, AS_Sub=0.
REQ-026 Reset during RUN or FIN SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-027 Macro MULDIV_DIV_EN: when defined, divide SHALL be supported as specified.
REQ-028 When MULDIV_DIV_EN is undefined, the divide logic SHALL be omitted: op SHALL be treated as 0 (every operation multiplies) and div_by_zero SHALL be tied 0.

Verification
REQ-029 Multiply FFFFFFFF*FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001; done exactly in the cycle after E32; busy high from E0 through FIN.
REQ-030 Divide 100/7 -> Lo=14, Hi=2; divide FFFFFFFF/80000000 (top-bit path) -> Lo=1, Hi=7FFFFFFF.
REQ-031 Divide 123/0 -> done the cycle after E0, Hi=123, Lo=FFFFFFFF, div_by_zero=1; a following multiply 3*5 -> Lo=15, Hi=0, div_by_zero=0.
REQ-032 start pulsed during RUN and during FIN -> no extra operation, exactly one done pulse; Hi/Lo unchanged afterward.
REQ-033 rst_n low at iteration 10 of a multiply -> all outputs 0 immediately, no done; after release, 6*7 -> Lo=42.
REQ-034 Built without MULDIV_DIV_EN, op=1 with A=6, B=7 -> Lo=42, Hi=0, div_by_zero=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential 32x32 unsigned multiplier / divider built around an external shared
// 32-bit add/sub unit. One shift-add or restoring-divide step per RUN cycle.
// Optional feature macro: MULDIV_DIV_EN (defined = divide supported; undefined =
// every operation multiplies and div_by_zero is tied low).
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        div_by_zero,
    output logic [31:0] AS_X,
    output logic [31:0] AS_Y,
    output logic        AS_Sub,
    input  logic [31:0] AS_S
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] b_q, b_d;
    logic        carry;

`ifdef MULDIV_DIV_EN
    logic        op_q, op_d;
    logic        dbz_q, dbz_d;
    logic [31:0] rem_sh;
    logic        rem_top;
    logic        borrow;
    logic        take;
`else
    logic        unused_op;
    assign unused_op = op;
`endif

    // Recover carry/borrow from operand MSBs and the sum MSB (the unit has no carry-out).
    always_comb begin
        carry = (hi_q[31] & b_q[31]) | ((hi_q[31] | b_q[31]) & ~AS_S[31]);
`ifdef MULDIV_DIV_EN
        rem_sh  = {hi_q[30:0], lo_q[31]};
        rem_top = hi_q[31];
        borrow  = (~rem_sh[31] & b_q[31]) | (~(rem_sh[31] ^ b_q[31]) & AS_S[31]);
        take    = rem_top | ~borrow;
`endif
    end

    // Add/sub unit operands come from registered state only.
    always_comb begin
        AS_X   = 32'd0;
        AS_Y   = 32'd0;
        AS_Sub = 1'b0;
        if (state_q == StRun) begin
            AS_Y = b_q;
`ifdef MULDIV_DIV_EN
            if (op_q) begin
                AS_X   = rem_sh;
                AS_Sub = 1'b1;
            end else
`endif
            begin
                AS_X = hi_q;
            end
        end
    end

    // Status outputs.
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StFin);
        Hi   = hi_q;
        Lo   = lo_q;
`ifdef MULDIV_DIV_EN
        div_by_zero = dbz_q;
`else
        div_by_zero = 1'b0;
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
`ifdef MULDIV_DIV_EN
        op_d    = op_q;
        dbz_d   = dbz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    b_d     = B;
                    hi_d    = 32'd0;
                    lo_d    = A;
                    cnt_d   = 5'd31;
                    state_d = StRun;
`ifdef MULDIV_DIV_EN
                    op_d  = op;
                    dbz_d = 1'b0;
                    // Divide by zero bypasses iteration entirely.
                    if (op && (B == 32'd0)) begin
                        hi_d    = A;
                        lo_d    = 32'hFFFF_FFFF;
                        dbz_d   = 1'b1;
                        state_d = StFin;
                    end
`endif
                end
            end
            StRun: begin
                cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = StFin;
                end
`ifdef MULDIV_DIV_EN
                if (op_q) begin
                    if (take) begin
                        hi_d = AS_S;
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = rem_sh;
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end else
`endif
                begin
                    if (lo_q[0]) begin
                        hi_d = {carry, AS_S[31:1]};
                        lo_d = {AS_S[0], lo_q[31:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[31:1]};
                        lo_d = {hi_q[0], lo_q[31:1]};
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            b_q     <= 32'd0;
`ifdef MULDIV_DIV_EN
            op_q    <= 1'b0;
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
`ifdef MULDIV_DIV_EN
            op_q    <= op_d;
            dbz_q   <= dbz_d;
`endif
        end
    end

endmodule
